// File: rtl/multi_pattern_blinker.sv
`default_nettype none
// ============================================================================
// Module      : multi_pattern_blinker
// Description : Multi-channel LED pattern player on a shared, phase-aligned
//               step timebase. Double-buffered loads commit at frame
//               boundaries. Optional macro BLINKER_FRAME_COUNT_EN adds a
//               16-bit frame_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_pattern_blinker #(
    parameter int CHANNELS       = 4,
    parameter int MESSAGE_WIDTH  = 32,
    parameter int INDEX_WIDTH    = 5,
    parameter int PRESCALE_WIDTH = 21,
    parameter int SEL_WIDTH      = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     enable,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [SEL_WIDTH-1:0]     load_channel,
    input  logic [MESSAGE_WIDTH-1:0] load_pattern,
    input  logic                     load_loop,
    output logic [CHANNELS-1:0]      LED,
    output logic [CHANNELS-1:0]      busy,
    output logic [INDEX_WIDTH-1:0]   step_index,
`ifdef BLINKER_FRAME_COUNT_EN
    output logic [15:0]              frame_count,
`endif
    output logic                     step_strobe
);

    localparam logic [INDEX_WIDTH-1:0] c_last_step = INDEX_WIDTH'(MESSAGE_WIDTH - 1);

    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [INDEX_WIDTH-1:0]    r_step;
    logic                      r_strobe;
    logic                      w_wrap;
    logic                      w_frame;
    logic [INDEX_WIDTH-1:0]    w_next_step;

    logic [CHANNELS-1:0]       w_sel;
    logic [CHANNELS-1:0]       w_pending;
    logic [CHANNELS-1:0]       w_running;
    logic [CHANNELS-1:0]       w_led;

    assign w_wrap      = enable & (&r_prescale);
    assign w_frame     = w_wrap & (r_step == c_last_step);
    assign w_next_step = w_wrap ? r_step + INDEX_WIDTH'(1) : r_step;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_prescale <= '0;
            r_step     <= '0;
            r_strobe   <= 1'b0;
        end else begin
            if (enable) begin
                r_prescale <= r_prescale + PRESCALE_WIDTH'(1);
            end
            r_step   <= w_next_step;
            r_strobe <= w_wrap;
        end
    end

    // An out-of-range channel selects nothing, so load_ready falls to 0.
    assign load_ready  = |(w_sel & ~w_pending);
    assign busy        = w_running | w_pending;
    assign LED         = w_led;
    assign step_index  = r_step;
    assign step_strobe = r_strobe;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            logic [MESSAGE_WIDTH-1:0] r_shadow;
            logic [MESSAGE_WIDTH-1:0] r_active;
            logic                     r_shadow_loop;
            logic                     r_active_loop;
            logic                     r_pend;
            logic                     r_run;
            logic                     r_led;
            logic                     w_accept;
            logic                     w_commit;
            logic                     w_run_next;
            logic [MESSAGE_WIDTH-1:0] w_pattern_next;

            assign w_sel[c]       = (load_channel == SEL_WIDTH'(c));
            // Accept requires pend=0 and commit requires pend=1, so they never collide.
            assign w_accept       = load_valid & load_ready & w_sel[c];
            assign w_commit       = w_frame & r_pend;
            assign w_run_next     = w_commit | (r_run & ~(w_frame & ~r_active_loop));
            assign w_pattern_next = w_commit ? r_shadow : r_active;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_shadow      <= '0;
                    r_active      <= '0;
                    r_shadow_loop <= 1'b0;
                    r_active_loop <= 1'b0;
                    r_pend        <= 1'b0;
                    r_run         <= 1'b0;
                    r_led         <= 1'b0;
                end else begin
                    if (w_accept) begin
                        r_shadow      <= load_pattern;
                        r_shadow_loop <= load_loop;
                    end
                    if (w_commit) begin
                        r_active      <= r_shadow;
                        r_active_loop <= r_shadow_loop;
                    end
                    r_pend <= w_accept | (r_pend & ~w_frame);
                    r_run  <= w_run_next;
                    r_led  <= w_pattern_next[w_next_step] & w_run_next;
                end
            end

            assign w_pending[c] = r_pend;
            assign w_running[c] = r_run;
            assign w_led[c]     = r_led;
        end
    endgenerate

`ifdef BLINKER_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_frame_count <= '0;
        end else if (w_frame) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_pattern_blinker.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_pattern_blinker
// Description : Self-checking bench for multi_pattern_blinker with a
//               cycle-level reference model feeding an expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_pattern_blinker;

    localparam int CH  = 4;
    localparam int MW  = 8;
    localparam int IW  = 3;
    localparam int PW  = 2;
    localparam int SW  = 2;

    logic          CLK;
    logic          RST_N;
    logic          enable;
    logic          load_valid;
    logic          load_ready;
    logic [SW-1:0] load_channel;
    logic [MW-1:0] load_pattern;
    logic          load_loop;
    logic [CH-1:0] LED;
    logic [CH-1:0] busy;
    logic [IW-1:0] step_index;
    logic          step_strobe;
`ifdef BLINKER_FRAME_COUNT_EN
    logic [15:0]   frame_count;
`endif

    multi_pattern_blinker #(
        .CHANNELS       (CH),
        .MESSAGE_WIDTH  (MW),
        .INDEX_WIDTH    (IW),
        .PRESCALE_WIDTH (PW),
        .SEL_WIDTH      (SW)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .enable       (enable),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_channel (load_channel),
        .load_pattern (load_pattern),
        .load_loop    (load_loop),
        .LED          (LED),
        .busy         (busy),
        .step_index   (step_index),
`ifdef BLINKER_FRAME_COUNT_EN
        .frame_count  (frame_count),
`endif
        .step_strobe  (step_strobe)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [CH-1:0] led;
        logic [CH-1:0] busy;
        logic [IW-1:0] step;
        logic          strobe;
    } exp_t;

    exp_t q_exp[$];

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int            m_pre;
    int            m_step;
    logic [CH-1:0] m_pend;
    logic [CH-1:0] m_run;
    logic [CH-1:0] m_sloop;
    logic [CH-1:0] m_aloop;
    logic [CH-1:0] m_led;
    logic [MW-1:0] m_sh  [CH];
    logic [MW-1:0] m_act [CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pre   = 0;
        m_step  = 0;
        m_pend  = '0;
        m_run   = '0;
        m_sloop = '0;
        m_aloop = '0;
        m_led   = '0;
        for (int c = 0; c < CH; c++) begin
            m_sh[c]  = '0;
            m_act[c] = '0;
        end
    endtask

    // Inputs are set by the caller; advance model and DUT one clock and compare.
    task automatic tick();
        exp_t e;
        exp_t o;
        logic rdy;
        logic acc;
        logic wrap;
        logic frame;
        logic [MW-1:0] pat;
        #1;
        rdy = !m_pend[load_channel];
        chk("load_ready", {31'd0, load_ready}, {31'd0, rdy});
        acc   = load_valid && rdy;
        wrap  = enable && (m_pre == (1 << PW) - 1);
        frame = wrap && (m_step == MW - 1);
        if (enable) m_pre = (m_pre + 1) % (1 << PW);
        if (wrap)   m_step = (m_step + 1) % MW;
        for (int c = 0; c < CH; c++) begin
            if (frame) begin
                if (m_pend[c]) begin
                    m_act[c]   = m_sh[c];
                    m_aloop[c] = m_sloop[c];
                    m_run[c]   = 1'b1;
                    m_pend[c]  = 1'b0;
                end else if (m_run[c] && !m_aloop[c]) begin
                    m_run[c] = 1'b0;
                end
            end
        end
        if (acc) begin
            m_sh[load_channel]    = load_pattern;
            m_sloop[load_channel] = load_loop;
            m_pend[load_channel]  = 1'b1;
        end
        for (int c = 0; c < CH; c++) begin
            pat      = m_act[c];
            m_led[c] = pat[m_step] & m_run[c];
        end
        e.led    = m_led;
        e.busy   = m_run | m_pend;
        e.step   = IW'(m_step);
        e.strobe = wrap;
        q_exp.push_back(e);
        @(posedge CLK);
        #1;
        o = q_exp.pop_front();
        chk("led",    {28'd0, LED},         {28'd0, o.led});
        chk("busy",   {28'd0, busy},        {28'd0, o.busy});
        chk("step",   {29'd0, step_index},  {29'd0, o.step});
        chk("strobe", {31'd0, step_strobe}, {31'd0, o.strobe});
    endtask

    task automatic wait_step(input int s);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (step_strobe && step_index == IW'(s)) found = 1'b1;
        end
        chk("wait_step_timeout", {31'd0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MW-1:0] p0;
        int            ones;
        logic [IW-1:0] held;

        RST_N        = 1'b0;
        enable       = 1'b1;
        load_valid   = 1'b0;
        load_channel = '0;
        load_pattern = '0;
        load_loop    = 1'b0;
        model_reset();

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_led",    {28'd0, LED},         32'd0);
        chk("rst_busy",   {28'd0, busy},        32'd0);
        chk("rst_step",   {29'd0, step_index},  32'd0);
        chk("rst_strobe", {31'd0, step_strobe}, 32'd0);
        for (int c = 0; c < CH; c++) begin
            load_channel = SW'(c);
            #1;
            chk("rst_ready", {31'd0, load_ready}, 32'd1);
        end
        load_channel = '0;
        RST_N = 1'b1;

        // Looping pattern on ch0 and one-shot all-ones on ch1, loaded mid-frame
        repeat (10) tick();
        p0           = 8'b1011_0001;
        load_valid   = 1'b1;
        load_channel = 2'd0;
        load_pattern = p0;
        load_loop    = 1'b1;
        tick();
        load_channel = 2'd1;
        load_pattern = 8'hFF;
        load_loop    = 1'b0;
        tick();
        load_valid = 1'b0;
        chk("led0_before_commit", {31'd0, LED[0]}, 32'd0);
        wait_step(0);
        ones = 0;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) tick();
            chk("led0_seq", {31'd0, LED[0]}, {31'd0, p0[(k / 4) % 8]});
            if (LED[1]) ones++;
        end
        chk("led1_ones", ones, 32);
        chk("busy1_done", {31'd0, busy[1]}, 32'd0);

        // Double load on ch2 before a boundary
        load_valid   = 1'b1;
        load_channel = 2'd2;
        load_pattern = 8'h5A;
        load_loop    = 1'b1;
        tick();
        load_pattern = 8'h33;
        #1;
        chk("ch2_second_ready", {31'd0, load_ready}, 32'd0);
        tick();
        load_valid = 1'b0;
        wait_step(0);
        load_valid   = 1'b1;
        load_pattern = 8'hC3;
        #1;
        chk("ch2_ready_after_commit", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        #1;
        chk("ch2_ready_after_accept", {31'd0, load_ready}, 32'd0);

        // Freeze the timebase for 10 clocks at step 3
        wait_step(3);
        enable = 1'b0;
        held   = step_index;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_step",   {29'd0, step_index},  {29'd0, held});
            chk("hold_strobe", {31'd0, step_strobe}, 32'd0);
        end
        enable = 1'b1;
        repeat (20) tick();

        // Mid-frame reset with ch0 pending and ch1 running
        load_valid   = 1'b1;
        load_channel = 2'd1;
        load_pattern = 8'hFF;
        load_loop    = 1'b1;
        tick();
        load_valid = 1'b0;
        wait_step(0);
        repeat (5) tick();
        load_valid   = 1'b1;
        load_channel = 2'd0;
        load_pattern = 8'h0F;
        load_loop    = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", {28'd0, busy}, {28'd0, 4'b0111});
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_led",  {28'd0, LED},  32'd0);
        chk("async_rst_busy", {28'd0, busy}, 32'd0);
        model_reset();
        q_exp.delete();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hold_step", {29'd0, step_index}, 32'd0);
        RST_N = 1'b1;
        repeat (40) tick();
        chk("no_commit_after_rst", {28'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
